// File: rtl/graph_exp_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : graph_exp_seq_if
// Description : Signal bundle for the graph exp sequencer: input element
//               stream, exp ROM lookup port, exp result stream, vector sum
//               and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface graph_exp_seq_if #(
    parameter int SUM_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic [7:0]       lut_addr;
    logic [7:0]       lut_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             sum_valid;
    logic [SUM_W-1:0] sum_data;
    logic             busy;
    logic             err_len;

    // Sequencer view
    modport slave (
        input  in_valid, in_data, in_last, lut_data, out_ready,
        output in_ready, lut_addr, out_valid, out_data, out_last,
               sum_valid, sum_data, busy, err_len
    );

    // Environment view (element source, exp ROM, result sink)
    modport master (
        output in_valid, in_data, in_last, lut_data, out_ready,
        input  in_ready, lut_addr, out_valid, out_data, out_last,
               sum_valid, sum_data, busy, err_len
    );
endinterface
`default_nettype wire

// File: rtl/graph_exp_seq.sv
`default_nettype none
// ============================================================================
// Module      : graph_exp_seq
// Description : Numerically stable exp stage ahead of softmax. Buffers one
//               int8 vector, tracks its maximum, then looks up
//               exp(x - max) in a 1-cycle registered ROM per element,
//               streams the results and reports their sum.
// Revision    : 1.0 - initial release
// ============================================================================
module graph_exp_seq #(
    parameter int MAX_LEN = 64,
    parameter int SUM_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    graph_exp_seq_if.slave bus
);

    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOOKUP = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic signed [7:0] r_buf [MAX_LEN];
    logic signed [7:0] r_max;
    logic [c_CW-1:0]   r_cnt;
    logic [c_AW-1:0]   r_idx;
    logic [7:0]        r_lut_addr;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_sum_valid;
    logic [SUM_W-1:0]  r_sum;
    logic              r_err_len;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_room;
    logic signed [7:0] w_elem;
    logic [8:0]        w_diff;
    logic [7:0]        w_addr;
    logic              w_is_last;

    assign w_in_ready = rst_n & ((r_state == S_IDLE) | (r_state == S_LOAD));
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready & (r_state == S_EMIT);
    assign w_room     = (r_cnt < c_CW'(MAX_LEN));

    // Element minus max is always <= 0; anything below -128 saturates to 0x80
    assign w_elem    = r_buf[r_idx];
    assign w_diff    = {w_elem[7], w_elem} - {r_max[7], r_max};
    assign w_addr    = (w_diff[8] & ~w_diff[7]) ? 8'h80 : w_diff[7:0];
    assign w_is_last = (c_CW'(r_idx) == (r_cnt - 1'b1));

    // Address is live in LOOKUP so the ROM registers it that edge; held after
    assign bus.lut_addr  = (r_state == S_LOOKUP) ? w_addr : r_lut_addr;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.sum_valid = r_sum_valid;
    assign bus.sum_data  = r_sum;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err_len   = r_err_len;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_in_fire) w_state_nxt = bus.in_last ? S_LOOKUP : S_LOAD;
            S_LOAD:   if (w_in_fire && bus.in_last) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_EMIT;
            S_EMIT:   if (w_out_fire) w_state_nxt = r_out_last ? S_IDLE : S_LOOKUP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Vector storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_in_fire && (r_state == S_IDLE))
            r_buf[0] <= $signed(bus.in_data);
        else if (w_in_fire && (r_state == S_LOAD) && w_room)
            r_buf[r_cnt[c_AW-1:0]] <= $signed(bus.in_data);
    end

    // Datapath: max/count tracking, ROM capture, output stream and sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_lut_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum       <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_max     <= $signed(bus.in_data);
                        r_cnt     <= c_CW'(1);
                        r_idx     <= '0;
                        r_sum     <= '0;
                        r_err_len <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        if (w_room) begin
                            if ($signed(bus.in_data) > r_max)
                                r_max <= $signed(bus.in_data);
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_err_len <= 1'b1;
                        end
                        if (bus.in_last)
                            r_idx <= '0;
                    end
                end
                S_LOOKUP: r_lut_addr <= w_addr;
                S_WAIT: begin
                    r_out_data  <= bus.lut_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_is_last;
                    r_sum       <= r_sum + SUM_W'(bus.lut_data);
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) r_sum_valid <= 1'b1;
                        else            r_idx       <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/graph_exp_seq.md
Name: graph_exp_seq

Overview:
- Sequencer that initiates lookups into the graph exp ROM. The ROM is a 1-cycle registered lookup: 8-bit signed address in, signed int8 exp result out, scale /32.
- Buffers one int8 vector, finds its maximum, then subtracts the max from each element and looks it up in the exp ROM.
- Streams the exp values out and reports their sum. This is the numerically stable exp stage ahead of softmax normalisation in the graph engine.

Parameters:
- MAX_LEN, 64, vector buffer depth in elements.
- SUM_W, 16, sum accumulator width; must satisfy 2^SUM_W > MAX_LEN*32.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when in_valid&in_ready
- in_data  in  8  signed int8 element
- in_last  in  1  final element of vector
- lut_addr  out  8  address driven to exp ROM
- lut_data  in  8  exp ROM output, valid the cycle after lut_addr is presented
- out_valid  out  1  exp result valid
- out_ready  in  1  downstream accept
- out_data  out  8  exp value (unsigned 1..32 in practice)
- out_last  out  1  final exp value of vector
- sum_valid  out  1  one-cycle pulse: sum_data final
- sum_data  out  SUM_W  sum of all out_data for the vector, held until next vector's first accepted beat
- busy  out  1  state != IDLE
- err_len  out  1  sticky: current/last vector exceeded MAX_LEN; cleared on next vector's first beat

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0 during reset.
- Outputs after reset: out_valid=0, out_last=0, out_data=0, sum_valid=0, sum_data=0, lut_addr=0, err_len=0, busy=0; counters and max cleared.
- Reset mid-vector aborts with no outputs; the buffer contents are don't-care.

State IDLE (in_ready=1):
- The first accepted beat writes buf[0], sets max=in_data, cnt=1, clears sum and err_len, and goes to LOAD.
- If that beat has in_last, go directly to LOOKUP.

State LOAD (in_ready=1):
- On each accepted beat, if cnt<MAX_LEN: write buf[cnt], update max = signed max, increment cnt.
- Otherwise drop the beat and set err_len.
- On an accepted in_last, set idx=0 and go to LOOKUP.

State LOOKUP (in_ready=0):
- Drive lut_addr = sat8(buf[idx] - max), then go to WAIT.
- The difference is computed 9-bit signed, range [-255,0]. Values below -128 clamp to 8'h80; otherwise the low 8 bits are used.

State WAIT:
- lut_addr held. At the clock edge, out_data <= lut_data, out_valid <= 1, out_last <= (idx==cnt-1), sum += zero-extend(lut_data). Go to EMIT.

State EMIT:
- out_valid=1; out_data and out_last stable until out_valid&out_ready.
- On accept:
  - if not last: idx++, out_valid <= 0, go to LOOKUP.
  - if last: out_valid <= 0, sum_valid <= 1 for one cycle, go to IDLE.

Throughput and latency:
- Throughput is 1 element per 3 cycles with out_ready held high.
- First out_valid rises 2 cycles after entering LOOKUP.

Other rules:
- in_ready=0 in LOOKUP/WAIT/EMIT; the next vector is accepted only from IDLE, which can be the cycle after sum_valid.
- sum_data is never written with overflow, by the parameter constraint.
- The max element always maps to lut_addr=0x00, so its exp value is 32.

Test Plan:
- Vector [0, 32, -32] (last on -32), out_ready=1 -> lut_addr 0xE0, 0x00, 0xC0; out_data 12, 32, 4; out_last on third; sum_valid pulse with sum_data=48; first out_valid 2 cycles after last input accepted+1.
- Vector [127, -128] -> difference -255 clamps to lut_addr 0x80; out_data 32, 1; sum_data=33.
- Single-element vector [-50] with in_last -> IDLE→LOOKUP, lut_addr 0x00, out_data 32, out_last=1, sum_data=32.
- Backpressure: out_ready=0 for 5 cycles during the second beat of the first vector -> out_valid held, out_data stable, no extra lut_addr change, results identical to the first test.
- MAX_LEN=4: send 6 beats [0,0,0,0,64,64], last on the sixth -> err_len=1, only 4 outputs each 32, sum_data=128; the next vector's first beat clears err_len.
- Assert rst_n=0 while in EMIT -> out_valid, sum_valid, busy drop to 0 immediately; after release, vector [5] yields out_data 32, sum_data=32.
